branch_pred_gshare: RTL and testbench

- Parametrised successor to the pipeline's fixed bimodal branch predictor.
- Indexes a 2-bit saturating-counter PHT with either PC bits (bimodal) or PC XOR speculative global history (gshare).
- Checkpoints the history per branch, repairs it on mispredict from M-stage feedback, and initialises the PHT with a sweep FSM.
- Sits beside the F/D pipeline registers; updates come from M.

---
 rtl/branch_pred_gshare.sv | 194 +++++++++++++++++++
 tb/tb_branch_pred_gshare.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_gshare.sv
`default_nettype none
// ============================================================================
// Module      : branch_pred_gshare
// Description : Bimodal/gshare branch predictor with 2-bit counter PHT,
//               speculative GHR with mispredict repair and PHT init sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_gshare #(
    parameter int         IDX_W    = 10,
    parameter int         GHR_W    = 8,
    parameter int         MODE     = 1,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              init_busy,
    input  logic [31:0]       pcF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              branchD,
    output logic              pred_takeD,
    output logic [IDX_W-1:0]  pht_idxD,
    output logic [GHR_W-1:0]  ghr_snapD,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic [GHR_W-1:0]  upd_ghr,
    input  logic              upd_pred,
    input  logic              upd_actual,
    output logic              mispredM,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);

    localparam int             c_ENTRIES = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] c_LAST  = {IDX_W{1'b1}};
    localparam logic [0:0]     c_INIT    = 1'b0;
    localparam logic [0:0]     c_READY   = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_stateNext;
    logic [IDX_W-1:0] r_sweepCnt;
    logic [IDX_W-1:0] w_sweepNext;
    logic [GHR_W-1:0] r_ghr;
    logic [IDX_W-1:0] r_idxD;
    logic [IDX_W-1:0] w_idxF;
    logic [GHR_W-1:0] w_ghrRepair;
    logic [GHR_W-1:0] w_ghrShift;
    logic [1:0]       w_ctrCur;
    logic [1:0]       w_ctrNext;
    logic [31:0]      r_statBranches;
    logic [31:0]      r_statMispred;
    logic [1:0]       r_pht [c_ENTRIES];

    logic w_unusedPc;
    assign w_unusedPc = ^{pcF[31:IDX_W+2], pcF[1:0]};

    // ------------------------------------------------------------------
    // Init sweep FSM
    // ------------------------------------------------------------------
    assign init_busy = (r_state == c_INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_INIT;
            r_sweepCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_sweepCnt <= w_sweepNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_sweepNext = r_sweepCnt;
        case (r_state)
            c_INIT: begin
                if (clr) begin
                    w_sweepNext = '0;
                end else if (r_sweepCnt == c_LAST) begin
                    w_stateNext = c_READY;
                    w_sweepNext = '0;
                end else begin
                    w_sweepNext = r_sweepCnt + 1'b1;
                end
            end
            default: begin
                if (clr) begin
                    w_stateNext = c_INIT;
                    w_sweepNext = '0;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Index generation and GHR next-value forms
    // ------------------------------------------------------------------
    generate
        if (MODE == 0) begin : g_modeBimodal
            assign w_idxF = pcF[IDX_W+1:2];
        end else begin : g_modeGshare
            assign w_idxF = pcF[IDX_W+1:2] ^ IDX_W'(r_ghr);
        end

        if (GHR_W > 1) begin : g_ghrWide
            logic w_unusedGhr;
            assign w_unusedGhr = upd_ghr[GHR_W-1];
            assign w_ghrRepair = {upd_ghr[GHR_W-2:0], upd_actual};
            assign w_ghrShift  = {r_ghr[GHR_W-2:0], pred_takeD};
        end else begin : g_ghrOne
            logic w_unusedGhr;
            assign w_unusedGhr = upd_ghr[0];
            assign w_ghrRepair = upd_actual;
            assign w_ghrShift  = pred_takeD;
        end
    endgenerate

    assign mispredM   = upd_valid & (upd_pred != upd_actual);
    assign pht_idxD   = r_idxD;
    assign ghr_snapD  = r_ghr;
    assign pred_takeD = branchD & ~init_busy & r_pht[r_idxD][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idxD <= '0;
        end else if (flushD) begin
            r_idxD <= '0;
        end else if (!stallD) begin
            r_idxD <= w_idxF;
        end
    end

    // Repair from M outranks the D-stage speculative shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (clr) begin
            r_ghr <= '0;
        end else if (mispredM) begin
            r_ghr <= w_ghrRepair;
        end else if (branchD & ~stallD & ~flushD & ~init_busy) begin
            r_ghr <= w_ghrShift;
        end
    end

    // ------------------------------------------------------------------
    // PHT: RAM-style, never reset; filled by the sweep instead
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrCur  = r_pht[upd_idx];
        w_ctrNext = w_ctrCur;
        if (upd_actual) begin
            if (w_ctrCur != 2'b11) begin
                w_ctrNext = w_ctrCur + 2'b01;
            end
        end else if (w_ctrCur != 2'b00) begin
            w_ctrNext = w_ctrCur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (init_busy) begin
            r_pht[r_sweepCnt] <= CTR_INIT;
        end else if (upd_valid) begin
            r_pht[upd_idx] <= w_ctrNext;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_statBranches <= '0;
            r_statMispred  <= '0;
        end else if (clr) begin
            r_statBranches <= '0;
            r_statMispred  <= '0;
        end else if (!init_busy) begin
            if (upd_valid) begin
                r_statBranches <= r_statBranches + 32'd1;
            end
            if (mispredM) begin
                r_statMispred <= r_statMispred + 32'd1;
            end
        end
    end

    assign stat_branches = r_statBranches;
    assign stat_mispred  = r_statMispred;

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_gshare.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_pred_gshare
// Description : Scoreboard bench for branch_pred_gshare against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pred_gshare;

    localparam int         IDX_W    = 8;
    localparam int         GHR_W    = 8;
    localparam int         ENTRIES  = 2 ** IDX_W;
    localparam logic [1:0] CTR_INIT = 2'b01;

    logic              clk = 1'b0;
    logic              rst, clr, stallD, flushD, branchD;
    logic [31:0]       pcF;
    logic              upd_valid, upd_pred, upd_actual;
    logic [IDX_W-1:0]  upd_idx;
    logic [GHR_W-1:0]  upd_ghr;
    logic              init_busy, pred_takeD, mispredM;
    logic [IDX_W-1:0]  pht_idxD;
    logic [GHR_W-1:0]  ghr_snapD;
    logic [31:0]       stat_branches, stat_mispred;

    branch_pred_gshare #(.IDX_W(IDX_W), .GHR_W(GHR_W), .MODE(1), .CTR_INIT(CTR_INIT)) dut (
        .clk(clk), .rst(rst), .clr(clr), .init_busy(init_busy), .pcF(pcF),
        .stallD(stallD), .flushD(flushD), .branchD(branchD), .pred_takeD(pred_takeD),
        .pht_idxD(pht_idxD), .ghr_snapD(ghr_snapD), .upd_valid(upd_valid),
        .upd_idx(upd_idx), .upd_ghr(upd_ghr), .upd_pred(upd_pred),
        .upd_actual(upd_actual), .mispredM(mispredM),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, clr, br, st, fl, uv, up, ua;
        logic [31:0] pc;
        logic [7:0]  ui, ug;
    } stim_t;

    typedef struct {
        logic        pred, busy, mis;
        logic [7:0]  idx, snap;
        logic [31:0] br, mp;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: plain integers/arrays following the predictor rules
    int          mPht [ENTRIES];
    int          mSweep;
    bit          mBusy;
    logic [7:0]  mGhr, mIdxD;
    logic [31:0] mBr, mMp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        logic [7:0] idxF;
        @(negedge clk);
        rst = s.rst; clr = s.clr; pcF = s.pc; branchD = s.br; stallD = s.st;
        flushD = s.fl; upd_valid = s.uv; upd_idx = s.ui; upd_ghr = s.ug;
        upd_pred = s.up; upd_actual = s.ua;
        if (s.rst) begin
            mBusy = 1; mSweep = 0; mGhr = 0; mIdxD = 0; mBr = 0; mMp = 0;
        end
        e.busy = mBusy;
        e.pred = s.br && !mBusy && (mPht[mIdxD] >= 2);
        e.idx  = mIdxD;
        e.snap = mGhr;
        e.mis  = s.uv && (s.up != s.ua);
        e.br   = mBr;
        e.mp   = mMp;
        q.push_back(e);
        if (!s.rst) begin
            idxF = s.pc[9:2] ^ mGhr;
            if (s.fl) mIdxD = 0;
            else if (!s.st) mIdxD = idxF;
            if (s.clr) mGhr = 0;
            else if (e.mis) mGhr = {s.ug[6:0], s.ua};
            else if (s.br && !s.st && !s.fl && !mBusy) mGhr = {mGhr[6:0], e.pred};
            if (!mBusy && s.uv) begin
                if (s.ua) mPht[s.ui] = (mPht[s.ui] == 3) ? 3 : mPht[s.ui] + 1;
                else      mPht[s.ui] = (mPht[s.ui] == 0) ? 0 : mPht[s.ui] - 1;
            end
            if (s.clr) begin
                mBr = 0; mMp = 0;
            end else if (!mBusy) begin
                if (s.uv) mBr = mBr + 1;
                if (e.mis) mMp = mMp + 1;
            end
            if (s.clr) begin
                mBusy = 1; mSweep = 0;
            end else if (mBusy) begin
                mPht[mSweep] = int'(CTR_INIT);
                mSweep++;
                if (mSweep == ENTRIES) mBusy = 0;
            end
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("init_busy",     {31'd0, init_busy},  {31'd0, e.busy});
            chk("pred_takeD",    {31'd0, pred_takeD}, {31'd0, e.pred});
            chk("pht_idxD",      {24'd0, pht_idxD},   {24'd0, e.idx});
            chk("ghr_snapD",     {24'd0, ghr_snapD},  {24'd0, e.snap});
            chk("mispredM",      {31'd0, mispredM},   {31'd0, e.mis});
            chk("stat_branches", stat_branches,       e.br);
            chk("stat_mispred",  stat_mispred,        e.mp);
        end
    end

    initial begin
        stim_t s;
        int busyCnt;
        for (int i = 0; i < ENTRIES; i++) mPht[i] = -1;
        rst = 1; clr = 0; pcF = 0; branchD = 0; stallD = 0; flushD = 0;
        upd_valid = 0; upd_idx = 0; upd_ghr = 0; upd_pred = 0; upd_actual = 0;

        // Reset with predictor inputs active
        s = idle(); s.rst = 1; s.br = 1;
        repeat (3) step(s);

        // Sweep: branches and updates must be ignored; count busy cycles
        busyCnt = 0;
        for (int i = 0; i < ENTRIES + 4; i++) begin
            s = idle(); s.br = 1; s.st = 1; s.pc = $urandom;
            s.uv = 1'($urandom); s.ui = 8'($urandom); s.up = 1; s.ua = 0;
            step(s);
            #3;
            if (init_busy) busyCnt++;
        end
        chk("sweep_length", busyCnt, ENTRIES);

        // Saturation on idx 0x10 (pcF=0x40, GHR=0): load, then hold D
        s = idle(); s.pc = 32'h40; step(s);
        for (int i = 0; i < 9; i++) begin
            s = idle(); s.br = 1; s.st = 1; s.uv = 1; s.ui = 8'h10;
            s.ua = (i < 4); s.up = ~s.ua;
            step(s);
        end
        for (int i = 0; i < 2; i++) begin
            s = idle(); s.br = 1; s.st = 1; s.uv = 1; s.ui = 8'h10; s.ua = 0;
            step(s);
        end

        // GHR -> 0x06 via repair, then pcF=0x100 yields idx 0x46
        s = idle(); s.uv = 1; s.ui = 8'h20; s.ug = 8'h03; s.up = 1; s.ua = 0; s.st = 1; step(s);
        s = idle(); s.pc = 32'h100; step(s);
        s = idle(); s.st = 1; step(s);

        // GHR -> 0xA5, then repair (0x3C,actual 0) beats a D-stage shift
        s = idle(); s.uv = 1; s.ug = 8'h52; s.up = 0; s.ua = 1; s.st = 1; step(s);
        s = idle(); s.br = 1; s.uv = 1; s.ug = 8'h3C; s.up = 1; s.ua = 0; step(s);
        s = idle(); s.st = 1; step(s);

        // Stall holds idx and blocks the shift; flush+stall clears idx
        s = idle(); s.pc = 32'h200; step(s);
        s = idle(); s.pc = 32'h3FC; s.br = 1; s.st = 1; step(s);
        s = idle(); s.pc = 32'h3FC; s.st = 1; s.fl = 1; step(s);
        s = idle(); s.st = 1; step(s);

        // Counter wrap from all-ones
        s = idle(); s.st = 1; step(s);
        #3;
        force dut.r_statBranches = 32'hFFFF_FFFF;
        #1;
        release dut.r_statBranches;
        mBr = 32'hFFFF_FFFF;
        s = idle(); s.st = 1; s.uv = 1; s.ui = 8'h33; s.up = 1; s.ua = 1; step(s);
        s = idle(); s.st = 1; step(s);

        // Soft clear restarts the sweep
        s = idle(); s.clr = 1; s.uv = 1; s.up = 1; step(s);
        for (int i = 0; i < ENTRIES + 2; i++) begin
            s = idle(); s.br = 1; s.uv = 1'($urandom); s.ui = 8'($urandom); step(s);
        end

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst = 0;
            s.clr = ($urandom_range(0, 999) == 0);
            s.pc  = $urandom;
            s.br  = 1'($urandom);
            s.st  = ($urandom_range(0, 7) == 0);
            s.fl  = ($urandom_range(0, 9) == 0);
            s.uv  = 1'($urandom);
            s.ui  = 8'($urandom);
            s.ug  = 8'($urandom);
            s.up  = 1'($urandom);
            s.ua  = 1'($urandom);
            step(s);
        end

        s = idle(); step(s);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
